// File: rtl/switch_pipeline_pkg.sv
// Shared definitions for the switch frame-path pipeline stages.
// Holds the skid-buffer state encoding and the handshake signal constants.
package switch_pipeline_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_BUSY  = 2'b01,
    ST_FULL  = 2'b10
  } skid_state_e;

  localparam int HS_WIDTH = 1;
  localparam logic [HS_WIDTH-1:0] HS_ASSERT   = 1'b1;
  localparam logic [HS_WIDTH-1:0] HS_DEASSERT = 1'b0;

endpackage

// File: rtl/register_areset.sv
// Register with clock enable, synchronous clear and async active-low reset.
// Latency 1 cycle; no backpressure (load is controlled by enable alone).
module register_areset #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clock,
  input  logic             areset_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Clear wins over enable so a simultaneous load is discarded.
  always_ff @(posedge clock or negedge areset_n) begin
    if (!areset_n) begin
      q <= RESET_VALUE;
    end else if (clear) begin
      q <= RESET_VALUE;
    end else if (enable) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipeline_skid_buffer.sv
// Two-entry ready/valid skid buffer; every output is driven straight from a flop.
// Latency 1 cycle; backpressure: at most one extra word is absorbed into skid, then input_ready drops.
module pipeline_skid_buffer
  import switch_pipeline_pkg::*;
#(
  parameter int                    WORD_WIDTH  = 8,
  parameter logic [WORD_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clock,
  input  logic                  areset_n,
  input  logic                  clear,
  input  logic                  input_valid,
  output logic                  input_ready,
  input  logic [WORD_WIDTH-1:0] input_data,
  output logic                  output_valid,
  input  logic                  output_ready,
  output logic [WORD_WIDTH-1:0] output_data
);

  logic [1:0]            state_bits;
  skid_state_e           state_q;
  skid_state_e           state_d;
  logic [WORD_WIDTH-1:0] main_q;
  logic [WORD_WIDTH-1:0] main_d;
  logic [WORD_WIDTH-1:0] skid_q;
  logic                  main_en;
  logic                  skid_en;
  logic                  input_ready_q;
  logic                  input_ready_d;
  logic                  output_valid_q;
  logic                  output_valid_d;
  logic                  insert;
  logic                  remove;

  always_comb state_q = skid_state_e'(state_bits);

  always_comb begin
    state_d        = state_q;
    main_d         = input_data;
    main_en        = 1'b0;
    skid_en        = 1'b0;
    insert         = input_valid & input_ready_q;
    remove         = output_valid_q & output_ready;

    case (state_q)
      ST_EMPTY: begin
        if (insert) begin
          state_d = ST_BUSY;
          main_en = 1'b1;
        end
      end
      ST_BUSY: begin
        if (insert && !remove) begin
          state_d = ST_FULL;
          skid_en = 1'b1;
        end else if (insert && remove) begin
          main_en = 1'b1;
        end else if (remove) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // input_ready is low here, so only a remove can happen.
        if (remove) begin
          state_d = ST_BUSY;
          main_d  = skid_q;
          main_en = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    // Handshake flags are registered copies of the next state's decode.
    input_ready_d  = (state_d != ST_FULL);
    output_valid_d = (state_d != ST_EMPTY);
  end

  register_areset #(.WIDTH(2), .RESET_VALUE(ST_EMPTY)) u_state (
    .clock(clock), .areset_n(areset_n), .clear(clear), .enable(1'b1),
    .d(state_d), .q(state_bits)
  );

  register_areset #(.WIDTH(WORD_WIDTH), .RESET_VALUE(RESET_VALUE)) u_main (
    .clock(clock), .areset_n(areset_n), .clear(clear), .enable(main_en),
    .d(main_d), .q(main_q)
  );

  register_areset #(.WIDTH(WORD_WIDTH), .RESET_VALUE(RESET_VALUE)) u_skid (
    .clock(clock), .areset_n(areset_n), .clear(clear), .enable(skid_en),
    .d(input_data), .q(skid_q)
  );

  register_areset #(.WIDTH(HS_WIDTH), .RESET_VALUE(HS_ASSERT)) u_input_ready (
    .clock(clock), .areset_n(areset_n), .clear(clear), .enable(1'b1),
    .d(input_ready_d), .q(input_ready_q)
  );

  register_areset #(.WIDTH(HS_WIDTH), .RESET_VALUE(HS_DEASSERT)) u_output_valid (
    .clock(clock), .areset_n(areset_n), .clear(clear), .enable(1'b1),
    .d(output_valid_d), .q(output_valid_q)
  );

  assign input_ready  = input_ready_q;
  assign output_valid = output_valid_q;
  assign output_data  = main_q;

endmodule

// File: doc/pipeline_skid_buffer.md
# pipeline_skid_buffer

Two-entry ready/valid skid buffer that decouples an upstream producer from a downstream consumer in the switch datapath. It provides full throughput (one word per cycle) while registering every output, including `input_ready`, so that no combinational path crosses the stage in either direction. Instances sit between pipeline stages of the frame path, ahead of stages built from plain storage registers.

## Interface
- `WORD_WIDTH`, default 8: data word width in bits; must be ≥1.
- `RESET_VALUE`, default 0: value loaded into both data registers on reset and on clear.

- `clock` in 1: single clock; all logic is on the rising edge.
- `areset_n` in 1: asynchronous, active-low reset. Assertion takes effect immediately. Deassertion must be synchronous to `clock`, which the upstream reset synchronizer guarantees.
- `clear` in 1: synchronous clear. Returns the block to the reset state on the next edge.
- `input_valid` in 1: upstream word is present.
- `input_ready` out 1: block can accept a word this cycle. Driven directly from a flop.
- `input_data` in `WORD_WIDTH`: upstream word.
- `output_valid` out 1: `output_data` holds a word. Driven directly from a flop.
- `output_ready` in 1: downstream accepts the word this cycle.
- `output_data` out `WORD_WIDTH`: downstream word. Driven directly from a flop.

## Operation
- Insert = `input_valid & input_ready`. Remove = `output_valid & output_ready`.
- Storage: `main` register drives `output_data`; `skid` register holds the overflow word.
- States:
  - EMPTY: `input_ready=1`, `output_valid=0`.
  - BUSY: `input_ready=1`, `output_valid=1`.
  - FULL: `input_ready=0`, `output_valid=1`.
- Transitions, each with its data action:
  - EMPTY, insert → BUSY. `main ← input_data`.
  - BUSY, insert and no remove → FULL. `skid ← input_data`.
  - BUSY, insert and remove → BUSY. `main ← input_data` (flow-through).
  - BUSY, remove and no insert → EMPTY.
  - FULL, remove → BUSY. `main ← skid`.
  - No transfer → hold state and data.
- Insert cannot occur in FULL. `input_valid` in FULL is ignored and the upstream must hold its word.
- Words leave in the order they arrived. No word is dropped or duplicated.
- Data registers load only on the enables listed above. There is no gating beyond those enables.
- Reset and clear:
  - Reset (`areset_n=0`) forces EMPTY, `input_ready=1`, `output_valid=0`, and `main=skid=RESET_VALUE`.
  - `clear=1` has the same effect at the next edge and overrides any simultaneous insert or remove. Those transfers are lost; the upstream and downstream agree on this by protocol.
- Mid-operation reset discards both stored words immediately, with no handshake.

## Timing
- Latency: a word inserted at edge N is visible on `output_data` with `output_valid=1` after edge N (EMPTY→BUSY): one cycle.
- Throughput: one word per cycle in steady state, with `output_ready` held at 1.
- Backpressure: `output_ready` falling in BUSY causes at most one additional accepted word, which goes into the skid. `input_ready` drops on the following cycle.
- Release: the first remove out of FULL raises `input_ready` on the next cycle.
- `input_ready`, `output_valid` and `output_data` change only on clock edges or asynchronous reset.
- The first cycle after `areset_n` rises: EMPTY, `input_ready=1`.

## Structure
- Shared package `switch_pipeline_pkg`:
  - State encoding constants: EMPTY=2'b00, BUSY=2'b01, FULL=2'b10.
  - Common handshake-width constants.
- Natural sub-module: `register_areset`, a register with clock enable, synchronous clear and asynchronous active-low reset. Instantiate it for `main`, `skid`, the state register, and the registered `input_ready`/`output_valid`.
- Next-state and enable logic is a single combinational block in `pipeline_skid_buffer`.

## Test plan
- Reset, then idle: `input_ready=1`, `output_valid=0`, `output_data=RESET_VALUE` throughout.
- Stream 0x01..0x10 with `output_ready=1`: outputs 0x01..0x10 in order, one per cycle, first word one cycle after its insert, `input_ready` constantly 1.
- In BUSY holding 0xA5, insert 0x3C with `output_ready=0`: state FULL, `input_ready=0` next cycle. Raise `output_ready`: out 0xA5 then 0x3C, `input_ready` back to 1 one cycle after the first remove.
- Random `input_valid`/`output_ready` over 10k words, checked against a scoreboard queue: no loss, no duplication, order kept, occupancy never exceeds 2.
- In FULL, assert `clear` together with `output_ready=1`: next cycle EMPTY, `output_valid=0`, data equals `RESET_VALUE`, and no word was transferred.
- Assert `areset_n=0` mid-stream between edges: outputs reach reset values immediately, before the next edge. After release, streaming 0x55 works normally.
